// File: rtl/ac97_regctl_pkg.sv
// Shared types and constants for the AC-link register command controller.
// Holds the controller state encoding, the codec init write table,
// TAG/slot bit positions and helpers that build command slot words.
package ac97_regctl_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_READY = 3'd0,
      ST_INIT       = 3'd1,
      ST_IDLE       = 3'd2,
      ST_ISSUE      = 3'd3,
      ST_WAIT_RSP   = 3'd4
   } state_t;

   localparam int INIT_LEN   = 4;
   localparam int INIT_IDX_W = $clog2(INIT_LEN);

   // Entry [0] is written first: master, headphone, PCM out, record select.
   localparam logic [INIT_LEN-1:0][6:0]  INIT_ADDR = {7'h1A, 7'h18, 7'h04, 7'h02};
   localparam logic [INIT_LEN-1:0][15:0] INIT_DATA = {16'h0000, 16'h0808, 16'h0000, 16'h0000};

   localparam int TAG_READY_BIT  = 15;
   localparam int TAG_SLOT1_BIT  = 14;
   localparam int TAG_SLOT2_BIT  = 13;

   localparam int SLOT1_RW_BIT   = 19;
   localparam int SLOT1_ADDR_MSB = 18;
   localparam int SLOT1_ADDR_LSB = 12;
   localparam int SLOT2_DATA_MSB = 19;
   localparam int SLOT2_DATA_LSB = 4;

   // Command address slot: read flag in the top bit, register index below it.
   function automatic logic [19:0] cmd_slot1(input logic rd, input logic [6:0] addr);
      return {rd, addr, 12'h000};
   endfunction

   // Command data slot: 16-bit data left-justified in the 20-bit slot.
   function automatic logic [19:0] cmd_slot2(input logic [15:0] data);
      return {data, 4'h0};
   endfunction

endpackage

// File: rtl/ac97_ready_debounce.sv
// Codec Ready debounce.
// Counts consecutive frame strobes with Codec Ready set while enabled;
// any strobe with Codec Ready clear restarts the count.
// Ports:
//   ac97_bitclk, ac97_rst : clock, synchronous active-high reset
//   i_strobe              : frame strobe
//   i_ready_bit           : Codec Ready bit of the input TAG
//   i_enable              : counting allowed (controller waiting for ready)
//   i_clear               : drop the debounced ready flag
//   o_codec_ready         : debounced Codec Ready
//   o_ready_hit           : single-cycle pulse on the strobe that completes the count
module ac97_ready_debounce #(
   parameter int READY_FRAMES = 4
) (
   input  logic ac97_bitclk,
   input  logic ac97_rst,
   input  logic i_strobe,
   input  logic i_ready_bit,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_codec_ready,
   output logic o_ready_hit
);

   localparam logic [3:0] LOAD = 4'(READY_FRAMES);

   logic [3:0] r_cnt;
   logic       r_codec_ready;

   assign o_ready_hit   = i_enable & i_strobe & i_ready_bit & (r_cnt == 4'd1);
   assign o_codec_ready = r_codec_ready;

   always_ff @(posedge ac97_bitclk) begin
      if (ac97_rst) begin
         r_cnt         <= LOAD;
         r_codec_ready <= 1'b0;
      end else begin
         // Down-counter: reloaded whenever the run of ready frames is broken.
         if (!i_enable || (i_strobe && !i_ready_bit)) begin
            r_cnt <= LOAD;
         end else if (i_strobe) begin
            r_cnt <= (r_cnt == 4'd1) ? LOAD : r_cnt - 4'd1;
         end

         if (i_clear) begin
            r_codec_ready <= 1'b0;
         end else if (o_ready_hit) begin
            r_codec_ready <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ac97_regctl.sv
// AC-link codec register command controller.
// Owns output slots 1/2. Waits for a debounced Codec Ready, writes the init
// table, then serves one host register read/write per frame and matches read
// responses from input slots 1/2 with a frame timeout.
// Ports:
//   ac97_bitclk, ac97_rst        : bit clock, synchronous active-high reset
//   ac97_strobe                  : one-cycle strobe at bit 0 of each frame
//   in_tag, in_slot1, in_slot2   : input TAG/slots latched from the previous frame
//   out_slot1(_valid), out_slot2(_valid) : command slots, held for a whole frame
//   req_*                        : host request handshake and payload
//   rsp_valid/rsp_rdata/rsp_timeout : completion pulse, read data, timeout flag
//   codec_ready, init_done       : status
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_WAIT_READY | debouncing Codec Ready, no commands driven
// ST_INIT       | issuing one init table write per frame
// ST_IDLE       | req_ready high, waiting for a host request
// ST_ISSUE      | request captured, command goes out at the next strobe
// ST_WAIT_RSP   | read issued, matching status slots or counting to timeout
module ac97_regctl
   import ac97_regctl_pkg::*;
#(
   parameter int READY_FRAMES   = 4,
   parameter int TIMEOUT_FRAMES = 8
) (
   input  logic        ac97_bitclk,
   input  logic        ac97_rst,
   input  logic        ac97_strobe,
   input  logic [15:0] in_tag,
   input  logic [19:0] in_slot1,
   input  logic [19:0] in_slot2,
   output logic [19:0] out_slot1,
   output logic        out_slot1_valid,
   output logic [19:0] out_slot2,
   output logic        out_slot2_valid,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [6:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        codec_ready,
   output logic        init_done
);

   localparam logic [7:0] TO_LOAD = 8'(TIMEOUT_FRAMES);

   state_t                r_state;
   logic                  r_req_write;
   logic [6:0]            r_req_addr;
   logic [15:0]           r_req_wdata;
   logic [INIT_IDX_W-1:0] r_idx;
   logic [7:0]            r_tcnt;
   logic [19:0]           r_slot1;
   logic [19:0]           r_slot2;
   logic                  r_slot1_v;
   logic                  r_slot2_v;
   logic                  r_rsp_valid;
   logic                  r_rsp_timeout;
   logic [15:0]           r_rsp_rdata;
   logic                  r_init_done;

   logic w_accept;
   logic w_ready_bit;
   logic w_ready_loss;
   logic w_pending;
   logic w_in_wait_ready;
   logic w_ready_hit;
   logic w_addr_match;
   logic w_unused_bits;

   assign w_ready_bit     = in_tag[TAG_READY_BIT];
   assign w_in_wait_ready = (r_state == ST_WAIT_READY);
   assign w_accept        = req_valid & req_ready;
   assign w_ready_loss    = ac97_strobe & ~w_ready_bit & ~w_in_wait_ready;
   // A request accepted in the very cycle ready is lost still gets a response.
   assign w_pending       = w_accept | (r_state == ST_ISSUE) | (r_state == ST_WAIT_RSP);
   // The first strobe after issue still carries the frame our command was
   // sent in, so a response can only be recognised from the second one on.
   assign w_addr_match    = in_tag[TAG_SLOT1_BIT]
                            & (in_slot1[SLOT1_ADDR_MSB:SLOT1_ADDR_LSB] == r_req_addr)
                            & (r_tcnt != TO_LOAD);
   assign w_unused_bits   = ^{in_tag[TAG_SLOT2_BIT:0], in_slot1[SLOT1_RW_BIT],
                              in_slot1[SLOT1_ADDR_LSB-1:0], in_slot2[SLOT2_DATA_LSB-1:0]};

   ac97_ready_debounce #(
      .READY_FRAMES (READY_FRAMES)
   ) u_ready_debounce (
      .ac97_bitclk   (ac97_bitclk),
      .ac97_rst      (ac97_rst),
      .i_strobe      (ac97_strobe),
      .i_ready_bit   (w_ready_bit),
      .i_enable      (w_in_wait_ready),
      .i_clear       (w_ready_loss),
      .o_codec_ready (codec_ready),
      .o_ready_hit   (w_ready_hit)
   );

   always_ff @(posedge ac97_bitclk) begin
      if (ac97_rst) begin
         r_state       <= ST_WAIT_READY;
         r_req_write   <= 1'b0;
         r_req_addr    <= '0;
         r_req_wdata   <= '0;
         r_idx         <= '0;
         r_tcnt        <= '0;
         r_slot1       <= '0;
         r_slot2       <= '0;
         r_slot1_v     <= 1'b0;
         r_slot2_v     <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_rsp_rdata   <= '0;
         r_init_done   <= 1'b0;
      end else begin
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_rsp_rdata   <= '0;

         if (w_accept) begin
            r_req_write <= req_write;
            r_req_addr  <= req_addr;
            r_req_wdata <= req_wdata;
            r_state     <= ST_ISSUE;
         end

         if (ac97_strobe) begin
            // Slots are idle unless a command is issued at this strobe.
            r_slot1   <= '0;
            r_slot2   <= '0;
            r_slot1_v <= 1'b0;
            r_slot2_v <= 1'b0;

            if (w_ready_loss) begin
               r_state     <= ST_WAIT_READY;
               r_init_done <= 1'b0;
               if (w_pending) begin
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
               end
            end else begin
               case (r_state)
                  ST_WAIT_READY: begin
                     if (w_ready_hit) begin
                        r_state <= ST_INIT;
                        r_idx   <= '0;
                     end
                  end
                  ST_INIT: begin
                     r_slot1   <= cmd_slot1(1'b0, INIT_ADDR[r_idx]);
                     r_slot2   <= cmd_slot2(INIT_DATA[r_idx]);
                     r_slot1_v <= 1'b1;
                     r_slot2_v <= 1'b1;
                     if (r_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
                        r_init_done <= 1'b1;
                        r_state     <= ST_IDLE;
                     end else begin
                        r_idx <= r_idx + 1'b1;
                     end
                  end
                  ST_ISSUE: begin
                     r_slot1_v <= 1'b1;
                     if (r_req_write) begin
                        r_slot1     <= cmd_slot1(1'b0, r_req_addr);
                        r_slot2     <= cmd_slot2(r_req_wdata);
                        r_slot2_v   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                     end else begin
                        r_slot1 <= cmd_slot1(1'b1, r_req_addr);
                        r_tcnt  <= TO_LOAD;
                        r_state <= ST_WAIT_RSP;
                     end
                  end
                  ST_WAIT_RSP: begin
                     if (w_addr_match) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= in_slot2[SLOT2_DATA_MSB:SLOT2_DATA_LSB];
                        r_state     <= ST_IDLE;
                     end else if (r_tcnt == 8'd1) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                     end else begin
                        r_tcnt <= r_tcnt - 8'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign req_ready       = (r_state == ST_IDLE);
   assign out_slot1       = r_slot1;
   assign out_slot1_valid = r_slot1_v;
   assign out_slot2       = r_slot2;
   assign out_slot2_valid = r_slot2_v;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_rdata       = r_rsp_rdata;
   assign rsp_timeout     = r_rsp_timeout;
   assign init_done       = r_init_done;

endmodule
